// File: rtl/renderer_pkg.sv
// Shared constants and state encoding for the ball sprite renderer.
package renderer_pkg;
  localparam int DISP_W  = 64;
  localparam int DISP_H  = 64;
  localparam int COORD_W = 6;
  localparam int COLOR_W = 12;
  localparam int CLR_W   = 12;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_e;
endpackage

// File: rtl/square_scanner.sv
// Walks a side x side square row-major and presents the coordinate of the offset it moves to next.
module square_scanner
  import renderer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] base_x_i,
  input  logic [COORD_W-1:0] base_y_i,
  input  logic [3:0]         side_i,
  output logic [COORD_W-1:0] px_o,
  output logic [COORD_W-1:0] py_o,
  output logic               in_bounds_o,
  output logic               last_o
);
  logic [2:0]       dx_q, dx_d;
  logic [2:0]       dy_q, dy_d;
  logic [3:0]       side_m1;
  logic [COORD_W:0] sum_x, sum_y;

  assign side_m1 = side_i - 4'd1;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance_i) begin
      if ({1'b0, dx_q} == side_m1) begin
        dx_d = '0;
        dy_d = dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // Sums are one bit wider than a coordinate so off-screen pixels are suppressed, not wrapped.
  assign sum_x       = {1'b0, base_x_i} + {4'b0000, dx_d};
  assign sum_y       = {1'b0, base_y_i} + {4'b0000, dy_d};
  assign px_o        = sum_x[COORD_W-1:0];
  assign py_o        = sum_y[COORD_W-1:0];
  assign in_bounds_o = (sum_x < (COORD_W+1)'(DISP_W)) && (sum_y < (COORD_W+1)'(DISP_H));
  assign last_o      = ({1'b0, dx_q} == side_m1) && ({1'b0, dy_q} == side_m1);
endmodule

// File: rtl/ball_renderer.sv
// Turns sprite position updates into a pixel write stream: screen clear after reset, then erase-old / draw-new per update.
module ball_renderer
  import renderer_pkg::*;
#(
  parameter int                 SIZE     = 3,
  parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COLOR_W-1:0] color,
  output logic               write_en,
  output logic [COORD_W-1:0] write_x,
  output logic [COORD_W-1:0] write_y,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               frame_done
);
  localparam logic [3:0] SIDE = 4'(SIZE);

  // Handshake: an update transfers on a clk edge where pos_valid and pos_ready are both high.
  state_e             state_q, state_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [COORD_W-1:0] new_x_q, new_y_q, old_x_q, old_y_q;
  logic [COLOR_W-1:0] new_col_q;
  logic               have_old_q;

  logic               we_q, we_d;
  logic [COORD_W-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic               fd_q, fd_d, pr_q, pr_d;

  logic               hs;
  logic               scan_start, scan_adv;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COLOR_W-1:0] draw_col;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               scan_in_bounds, scan_last;

  assign hs = pos_valid & pr_q;

  square_scanner u_scanner (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (scan_start),
    .advance_i   (scan_adv),
    .base_x_i    (base_x),
    .base_y_i    (base_y),
    .side_i      (SIDE),
    .px_o        (scan_x),
    .py_o        (scan_y),
    .in_bounds_o (scan_in_bounds),
    .last_o      (scan_last)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    base_x     = new_x_q;
    base_y     = new_y_q;
    draw_col   = new_col_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (hs) begin
          scan_start = 1'b1;
          if (have_old_q) begin
            state_d = ERASE;
            base_x  = old_x_q;
            base_y  = old_y_q;
          end else begin
            state_d  = DRAW;
            base_x   = pos_x;
            base_y   = pos_y;
            draw_col = color;
          end
        end
      end
      ERASE: begin
        if (scan_last) begin
          state_d    = DRAW;
          scan_start = 1'b1;
        end else begin
          scan_adv = 1'b1;
          base_x   = old_x_q;
          base_y   = old_y_q;
        end
      end
      DRAW: begin
        if (scan_last) state_d = DONE;
        else           scan_adv = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs are registered from the upcoming state, so the first scan pixel lands the cycle after the handshake.
  always_comb begin
    we_d  = 1'b0;
    wx_d  = scan_x;
    wy_d  = scan_y;
    col_d = BG_COLOR;
    if (state_q == CLEAR) begin
      we_d = 1'b1;
      wx_d = clr_cnt_q[COORD_W-1:0];
      wy_d = clr_cnt_q[CLR_W-1:COORD_W];
    end else if (state_d == ERASE) begin
      we_d = scan_in_bounds;
    end else if (state_d == DRAW) begin
      we_d  = scan_in_bounds;
      col_d = draw_col;
    end
    fd_d = (state_d == DONE);
    pr_d = (state_d == IDLE) && (state_q != CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      new_x_q    <= '0;
      new_y_q    <= '0;
      new_col_q  <= '0;
      old_x_q    <= '0;
      old_y_q    <= '0;
      have_old_q <= 1'b0;
      we_q       <= 1'b0;
      wx_q       <= '0;
      wy_q       <= '0;
      col_q      <= '0;
      fd_q       <= 1'b0;
      pr_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (state_q == IDLE && hs) begin
        new_x_q   <= pos_x;
        new_y_q   <= pos_y;
        new_col_q <= color;
      end
      if (state_q == DRAW && scan_last) begin
        old_x_q    <= new_x_q;
        old_y_q    <= new_y_q;
        have_old_q <= 1'b1;
      end
      we_q  <= we_d;
      wx_q  <= wx_d;
      wy_q  <= wy_d;
      col_q <= col_d;
      fd_q  <= fd_d;
      pr_q  <= pr_d;
    end
  end

  assign write_en    = we_q;
  assign write_x     = wx_q;
  assign write_y     = wy_q;
  assign pixel_color = col_q;
  assign frame_done  = fd_q;
  assign pos_ready   = pr_q;
endmodule

// File: tb/tb_ball_renderer.sv
// Cycle-exact bench for ball_renderer: a pixel-level model of clear/erase/draw drives an expected write queue.
module tb_ball_renderer;
  localparam int          S  = 3;
  localparam logic [11:0] BG = 12'h000;

  logic        clk;
  logic        resetn;
  logic        pos_valid;
  logic        pos_ready;
  logic [5:0]  pos_x, pos_y;
  logic [11:0] color;
  logic        write_en;
  logic [5:0]  write_x, write_y;
  logic [11:0] pixel_color;
  logic        frame_done;

  int checks;
  int errors;

  // Model state: last drawn sprite position, if any.
  int mo_x, mo_y;
  bit have_old_m;

  // {we, x[5:0], y[5:0], color[11:0], frame_done, pos_ready}
  logic [26:0] exp_q[$];

  ball_renderer #(.SIZE(S), .BG_COLOR(BG)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .color       (color),
    .write_en    (write_en),
    .write_x     (write_x),
    .write_y     (write_y),
    .pixel_color (pixel_color),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    logic [26:0] got;
    @(negedge clk);
    resetn    = 1'b0;
    pos_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {write_en, write_x, write_y, pixel_color, frame_done, pos_ready};
    checks++;
    if (got !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    resetn     = 1'b1;
    have_old_m = 1'b0;
  endtask

  task automatic check_clear();
    logic [26:0] got, exp;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      exp = {1'b1, 6'(i % 64), 6'(i / 64), BG, 1'b0, 1'b0};
      got = {write_en, write_x, write_y, pixel_color, frame_done, pos_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clear_pixel %0d: got %h want %h", i, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({write_en, frame_done, pos_ready} !== 3'b001) begin
      errors++;
      $display("FAIL clear_end: got we/fd/rdy %b want 001", {write_en, frame_done, pos_ready});
    end
  endtask

  task automatic push_square(input int bx, input int by, input logic [11:0] col);
    int sx, sy;
    bit we;
    for (int dy = 0; dy < S; dy++) begin
      for (int dx = 0; dx < S; dx++) begin
        sx = bx + dx;
        sy = by + dy;
        we = (sx < 64) && (sy < 64);
        exp_q.push_back({we, 6'(sx), 6'(sy), col, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic offer(input int x, input int y, input logic [11:0] c, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (pos_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got pos_ready %b want 1 within 50 cycles", pos_ready);
      ok = 1'b0;
      return;
    end
    pos_x     = 6'(x);
    pos_y     = 6'(y);
    color     = c;
    pos_valid = 1'b1;
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    pos_x     = 6'($urandom_range(0, 63));
    pos_y     = 6'($urandom_range(0, 63));
    color     = 12'($urandom);
    ok        = 1'b1;
  endtask

  // Called right after the handshake edge; checks every following cycle through the frame_done pulse.
  task automatic check_update(input int x, input int y, input logic [11:0] c, input bit junk);
    logic [26:0] got, exp, mask;
    int k;
    exp_q.delete();
    if (have_old_m) push_square(mo_x, mo_y, BG);
    push_square(x, y, c);
    exp_q.push_back({1'b0, 6'd0, 6'd0, 12'd0, 1'b1, 1'b0});
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      got  = {write_en, write_x, write_y, pixel_color, frame_done, pos_ready};
      mask = exp[26] ? 27'h7ffffff : 27'h4000003;
      checks++;
      if ((got & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL update(%0d,%0d) cycle %0d: got %h want %h (mask %h)", x, y, k + 1, got, exp, mask);
      end
      if (junk) begin
        pos_valid = 1'b1;
        pos_x     = 6'($urandom_range(0, 63));
        pos_y     = 6'($urandom_range(0, 63));
        color     = 12'($urandom);
      end
      k++;
    end
    mo_x       = x;
    mo_y       = y;
    have_old_m = 1'b1;
  endtask

  task automatic run_update(input int x, input int y, input logic [11:0] c, input bit junk);
    bit ok;
    offer(x, y, c, ok);
    if (ok) check_update(x, y, c, junk);
  endtask

  task automatic test_reset();
    do_reset();
    check_clear();
  endtask

  task automatic test_first_update();
    run_update(10, 20, 12'hF00, 1'b0);
  endtask

  task automatic test_second_update();
    run_update(11, 20, 12'h0F0, 1'b0);
  endtask

  task automatic test_corner();
    run_update(62, 63, 12'($urandom), 1'b0);
    run_update(30, 30, 12'($urandom), 1'b0);
    run_update(63, 5, 12'($urandom), 1'b0);
    run_update(5, 62, 12'($urandom), 1'b0);
  endtask

  task automatic test_ignore_valid();
    run_update(40, 41, 12'h00F, 1'b1);
    run_update(41, 42, 12'hABC, 1'b0);
  endtask

  task automatic test_same_position();
    run_update(41, 42, 12'h123, 1'b0);
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 16; i++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 63);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 63);
      run_update(x, y, 12'($urandom), 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    offer(20, 20, 12'hF0F, ok);
    repeat (S * S + 2) @(negedge clk);
    do_reset();
    check_clear();
    run_update(25, 26, 12'h5A5, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    pos_valid  = 1'b0;
    pos_x      = '0;
    pos_y      = '0;
    color      = '0;
    have_old_m = 1'b0;
    mo_x       = 0;
    mo_y       = 0;

    test_reset();
    test_first_update();
    test_second_update();
    test_corner();
    test_ignore_valid();
    test_same_position();
    test_random();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
- Sits between physics_engine and the display write port. Consumes ball-position updates and produces the pixel write stream (write_en/write_x/write_y/pixel_color) that the display frame buffer accepts.
- On each accepted update it erases the previously drawn square sprite to background, draws the new square, and then signals completion.
- After reset it sweeps the whole 64x64 buffer to background so that no stale frame-buffer contents remain visible.

Parameters:
- SIZE, 3, side length of the square sprite in pixels (1..8).
- BG_COLOR, 12'h000, RGB444 colour written on clear and erase.

Ports:
- clk  input  1  system clock (on-chip oscillator).
- resetn  input  1  synchronous active-low reset.
- pos_valid  input  1  new sprite position/colour offered.
- pos_ready  output  1  block can accept an update (high only in IDLE).
- pos_x  input  6  top-left column of the new sprite.
- pos_y  input  6  top-left row of the new sprite.
- color  input  12  RGB444 sprite colour.
- write_en  output  1  pixel write strobe to the display.
- write_x  output  6  write column.
- write_y  output  6  write row.
- pixel_color  output  12  write colour.
- frame_done  output  1  one-cycle pulse when a redraw completes.

Behaviour:
- Reset: resetn is sampled low on a clk edge. All outputs become 0, the state becomes CLEAR, the sweep counters become 0, and have_old=0. Reset mid-operation aborts any sweep immediately; the partially drawn sprite is not tracked.
- All outputs are registered. One pixel write is issued per cycle and there is no back-pressure from the display.
- CLEAR state:
  - Issues 4096 writes of BG_COLOR, x fastest: (0,0),(1,0)..(63,0),(0,1)..(63,63).
  - write_en is high on every one of these cycles.
  - After (63,63) it goes to IDLE. No frame_done is pulsed for the clear.
- IDLE state:
  - pos_ready=1 and write_en=0.
  - A handshake (pos_valid & pos_ready at an edge) latches pos_x/pos_y/color into new_*.
  - Next state is ERASE if have_old=1, else DRAW.
- ERASE state:
  - Scans dy=0..SIZE-1 (outer) and dx=0..SIZE-1 (inner) over the old_x/old_y square, writing BG_COLOR.
  - Takes SIZE*SIZE cycles, then goes to DRAW.
- DRAW state:
  - Same scan order over new_x/new_y, writing the latched colour.
  - Takes SIZE*SIZE cycles. Then old_* <= new_*, have_old <= 1, and the state goes to DONE.
- DONE state: frame_done=1 for exactly one cycle, then IDLE.
- Latency: the first erase/draw write appears in the cycle after the handshake edge. Full update costs, including DONE:
  - with a prior sprite: 2*SIZE*SIZE+1 cycles;
  - first update: SIZE*SIZE+1 cycles.
- Clipping:
  - Coordinates are computed 7 bits wide (base + d).
  - If either sum is >= 64, that cycle still elapses but write_en=0. No wrap-around to the opposite edge.
  - write_x/write_y still carry the low 6 bits in that cycle; their value is don't-care.
- pos_ready is low in CLEAR/ERASE/DRAW/DONE. pos_valid is ignored while pos_ready=0 and is not queued.
- An update to the same position as old_* still performs the full erase+draw.
- Inputs changing after the handshake have no effect on the update in progress.

Decomposition:
- renderer_pkg holds:
  - DISP_W=64, DISP_H=64, COORD_W=6, COLOR_W=12;
  - the state enum {CLEAR, IDLE, ERASE, DRAW, DONE}.
- One sub-module, square_scanner:
  - inputs: start, base_x, base_y, side;
  - outputs: dx/dy-offset coordinates, in_bounds, last.
  - It is reused for ERASE and DRAW; CLEAR uses its own 12-bit counter.

Test Plan:
- Reset release -> exactly 4096 consecutive write_en cycles of 12'h000 covering (0,0)..(63,63) in x-fastest order, then pos_ready=1, with no frame_done.
- First update (10,20,12'hF00) with SIZE=3 -> 9 writes of F00 at x 10..12, y 20..22 (row-major), then frame_done pulse; 10 cycles from the handshake.
- Second update (11,20,12'h0F0) -> 9 writes of 000 over the old square, then 9 writes of 0F0 over the new square, then frame_done; 19 cycles total; pos_ready low throughout.
- Update at (62,63) -> only (62,63) and (63,63) are written (write_en high in 2 of 9 draw cycles); the following erase likewise writes only those 2.
- pos_valid held high during DRAW with changing pos_x -> ignored; the next accepted value is the one present in the first IDLE cycle.
- resetn low for one cycle mid-DRAW -> outputs 0 next cycle, CLEAR restarts from (0,0), and the next update performs no erase.
